mcpu_io_bus: RTL and testbench

// Data-side memory system downstream of the MCPU core: decodes the core's ADDR register and
// RAM strobes, serves a word RAM plus memory-mapped I/O (byte output FIFO, byte input FIFO,

---
 rtl/mcpu_io_bus_pkg.sv | 27 ++
 rtl/mcpu_io_bus_if.sv | 29 ++
 rtl/mcpu_io_bus_fifo.sv | 71 +++++++
 rtl/mcpu_io_bus.sv | 156 +++++++++++++++
 tb/tb_mcpu_io_bus.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_io_bus_pkg.sv
// Shared definitions for the MCPU data-side memory system: I/O register map
// and the layout of the STATUS register.
package mcpu_io_bus_pkg;

    // Word offsets of the four registers inside the I/O window
    typedef enum logic [1:0] {
        REG_OUT_DATA = 2'd0,
        REG_IN_DATA  = 2'd1,
        REG_STATUS   = 2'd2,
        REG_CYCLE    = 2'd3
    } ioReg_e;

    // STATUS register image, MSB first; everything not named reads as zero
    typedef struct packed {
        logic [15:0] zeroHi;
        logic [7:0]  inCount;
        logic [2:0]  zeroMid;
        logic        ovf;
        logic        inFull;
        logic        inEmpty;
        logic        outEmpty;
        logic        outFull;
    } status_t;

    localparam int FIFO_BYTE_WIDTH = 8;

endpackage

// File: rtl/mcpu_io_bus_if.sv
// Core-side and byte-stream-side signals of the MCPU data bus, bundled so the
// memory system and its users share a single port definition.
interface mcpu_io_bus_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] rdata;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;

    // The core plus the external byte consumer/producer
    modport master (
        output addr, wdata, we, re, out_ready, in_data, in_valid,
        input  rdata, out_data, out_valid, in_ready
    );

    // The memory system itself
    modport slave (
        input  addr, wdata, we, re, out_ready, in_data, in_valid,
        output rdata, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/mcpu_io_bus_fifo.sv
// Small synchronous FIFO with a combinational head. Fullness/emptiness come
// from the registered count, so a push into a full FIFO is dropped even if a
// pop happens in the same cycle.
module mcpu_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; simultaneous push and pop leave the count alone
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared; stale entries are harmless once the pointers reset
    always_ff @(posedge clk) begin
        if (!reset && doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end
endmodule

// File: rtl/mcpu_io_bus.sv
// Data-side memory system behind the MCPU core: word RAM plus a four-register
// I/O window (output byte FIFO, input byte FIFO, STATUS, free-running CYCLE).
// Reads are combinational because the core samples rdata in the same cycle it
// raises re; every side effect happens on the clock edge.
module mcpu_io_bus
    import mcpu_io_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RAM_AW     = 10,
    parameter int                    FIFO_AW    = 3,
    parameter logic [DATA_WIDTH-1:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic          clk,
    input  logic          reset,
    mcpu_io_bus_if.slave  bus
);
    localparam int RAM_WORDS = 2 ** RAM_AW;

    logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];
    logic [DATA_WIDTH-1:0] ioOff;
    logic                  isRam;
    logic                  isIo;
    ioReg_e                ioSel;

    logic                  ramWe;
    logic                  outPush;
    logic                  outPop;
    logic                  inPush;
    logic                  inPop;
    logic                  statusWr;
    logic                  cycleWr;

    logic [7:0]            outHead;
    logic                  outFull;
    logic                  outEmpty;
    logic [FIFO_AW:0]      outCountUnused;
    logic [7:0]            inHead;
    logic                  inFull;
    logic                  inEmpty;
    logic [FIFO_AW:0]      inCount;

    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
    status_t               statusWord;
    logic [DATA_WIDTH-1:0] readData;

    // Address decode: RAM at the bottom, four I/O words at IO_BASE, nothing elsewhere
    assign isRam = ((bus.addr >> RAM_AW) == '0);
    assign ioOff = bus.addr - IO_BASE;
    assign isIo  = ((ioOff >> 2) == '0);
    assign ioSel = ioReg_e'(ioOff[1:0]);

    assign ramWe    = bus.we && isRam;
    assign outPush  = bus.we && isIo && (ioSel == REG_OUT_DATA);
    assign statusWr = bus.we && isIo && (ioSel == REG_STATUS);
    assign cycleWr  = bus.we && isIo && (ioSel == REG_CYCLE);
    assign inPop    = bus.re && isIo && (ioSel == REG_IN_DATA);
    assign outPop   = !outEmpty && bus.out_ready;
    assign inPush   = bus.in_valid && !inFull;

    mcpu_fifo #(
        .WIDTH (FIFO_BYTE_WIDTH),
        .AW    (FIFO_AW)
    ) outFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (outPush),
        .pop_i   (outPop),
        .data_i  (bus.wdata[7:0]),
        .head_o  (outHead),
        .full_o  (outFull),
        .empty_o (outEmpty),
        .count_o (outCountUnused)
    );

    mcpu_fifo #(
        .WIDTH (FIFO_BYTE_WIDTH),
        .AW    (FIFO_AW)
    ) inFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inPush),
        .pop_i   (inPop),
        .data_i  (bus.in_data),
        .head_o  (inHead),
        .full_o  (inFull),
        .empty_o (inEmpty),
        .count_o (inCount)
    );

    assign bus.out_data  = outHead;
    assign bus.out_valid = !outEmpty;
    assign bus.in_ready  = !inFull;

    // Sticky overflow flag and cycle counter; a CYCLE write beats the increment
    always_comb begin
        ovf_d   = ovf_q;
        cycle_d = cycle_q + DATA_WIDTH'(1);
        if (outPush && outFull) begin
            ovf_d = 1'b1;
        end
        if (statusWr) begin
            ovf_d = 1'b0;
        end
        if (cycleWr) begin
            cycle_d = '0;
        end
    end

    // Status/counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            cycle_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // Word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram_q[bus.addr[RAM_AW-1:0]] <= bus.wdata;
        end
    end

    // STATUS image assembled from both FIFOs and the overflow flag
    always_comb begin
        statusWord          = '0;
        statusWord.outFull  = outFull;
        statusWord.outEmpty = outEmpty;
        statusWord.inEmpty  = inEmpty;
        statusWord.inFull   = inFull;
        statusWord.ovf      = ovf_q;
        statusWord.inCount  = 8'(inCount);
    end

    // Combinational read mux; unmapped addresses and OUT_DATA read as zero
    always_comb begin
        readData = '0;
        if (isRam) begin
            readData = ram_q[bus.addr[RAM_AW-1:0]];
        end else if (isIo) begin
            case (ioSel)
                REG_OUT_DATA: readData = '0;
                REG_IN_DATA:  readData = inEmpty ? '0 : DATA_WIDTH'(inHead);
                REG_STATUS:   readData = DATA_WIDTH'(statusWord);
                REG_CYCLE:    readData = cycle_q;
                default:      readData = '0;
            endcase
        end
    end

    assign bus.rdata = readData;
endmodule

// File: tb/tb_mcpu_io_bus.sv
// Self-checking bench for mcpu_io_bus: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_mcpu_io_bus;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;
    localparam int          DEPTH   = 8;

    logic clk;
    logic reset;

    mcpu_io_bus_if #(.DATA_WIDTH(32)) bus ();

    mcpu_io_bus #(
        .DATA_WIDTH (32),
        .RAM_AW     (10),
        .FIFO_AW    (3),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    logic [31:0] ramModel [1024];
    bit          ramKnown [1024];
    logic [7:0]  outQ[$];
    logic [7:0]  inQ[$];
    bit          ovfModel = 0;
    logic [31:0] cycModel = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        s       = '0;
        s[0]    = (outQ.size() == DEPTH);
        s[1]    = (outQ.size() == 0);
        s[2]    = (inQ.size() == 0);
        s[3]    = (inQ.size() == DEPTH);
        s[4]    = ovfModel;
        s[15:8] = 8'(inQ.size());
        return s;
    endfunction

    task automatic modelRead(input logic [31:0] a, output logic [31:0] v, output bit known);
        logic [31:0] off;
        off   = a - IO_BASE;
        v     = '0;
        known = 1;
        if (a < 32'd1024) begin
            known = ramKnown[a[9:0]];
            v     = ramModel[a[9:0]];
        end else if (off < 32'd4) begin
            case (off)
                32'd1:   v = (inQ.size() > 0) ? {24'd0, inQ[0]} : 32'd0;
                32'd2:   v = modelStatus();
                32'd3:   v = cycModel;
                default: v = '0;
            endcase
        end
    endtask

    task automatic compareModel();
        logic [31:0] v;
        bit          known;
        modelRead(bus.addr, v, known);
        if (known) checkOutput("rdata", bus.rdata, v);
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, outQ.size() > 0});
        if (outQ.size() > 0) checkOutput("out_data", {24'd0, bus.out_data}, {24'd0, outQ[0]});
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, inQ.size() < DEPTH});
    endtask

    task automatic updateModel();
        int          outSz;
        int          inSz;
        logic [31:0] off;
        bit          io;
        outSz = outQ.size();
        inSz  = inQ.size();
        off   = bus.addr - IO_BASE;
        io    = (off < 32'd4);
        if (bus.we && bus.addr < 32'd1024) begin
            ramModel[bus.addr[9:0]] = bus.wdata;
            ramKnown[bus.addr[9:0]] = 1;
        end
        if (reset) begin
            outQ.delete();
            inQ.delete();
            ovfModel = 0;
            cycModel = 0;
        end else begin
            if (outSz > 0 && bus.out_ready) void'(outQ.pop_front());
            if (bus.we && io && off == 32'd0) begin
                if (outSz == DEPTH) ovfModel = 1;
                else outQ.push_back(bus.wdata[7:0]);
            end
            if (bus.we && io && off == 32'd2) ovfModel = 0;
            if (bus.re && io && off == 32'd1 && inSz > 0) void'(inQ.pop_front());
            if (bus.in_valid && inSz < DEPTH) inQ.push_back(bus.in_data);
            cycModel = (bus.we && io && off == 32'd3) ? 32'd0 : cycModel + 32'd1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareModel();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic setIdle();
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.we        = 1'b0;
        bus.re        = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic applyStimulus(input int readyBias);
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)       bus.addr = 32'($urandom_range(0, 15));
        else if (r < 8)  bus.addr = IO_BASE + 32'($urandom_range(0, 3));
        else if (r == 8) bus.addr = 32'h0000_4000;
        else             bus.addr = $urandom;
        bus.wdata = $urandom;
        r = $urandom_range(0, 9);
        bus.we = (r < 3) || (r == 6);
        bus.re = (r >= 3 && r <= 6);
        bus.out_ready = readyBias ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        bus.in_valid  = readyBias ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
        bus.in_data   = 8'($urandom);
        reset = ($urandom_range(0, 79) == 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ramKnown[i] = 0;
        setIdle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        bus.addr = IO_BASE + 32'd2;
        bus.re   = 1'b1;
        #1;
        checkOutput("reset_status", bus.rdata, 32'h0000_0006);
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();

        // Cycle counter after 100 non-reset cycles, then clear
        bus.re = 1'b0;
        repeat (99) tick();
        bus.addr = IO_BASE + 32'd3;
        bus.re   = 1'b1;
        #1;
        checkOutput("cycle_100", bus.rdata, 32'd100);
        bus.re = 1'b0;
        bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.re = 1'b1;
        tick();
        #1;
        checkOutput("cycle_after_clear", bus.rdata, 32'd1);
        bus.re = 1'b0;

        // RAM write and same-cycle read, unmapped address
        bus.addr  = 32'd5;
        bus.wdata = 32'hDEAD_BEEF;
        bus.we    = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.re = 1'b1;
        #1;
        checkOutput("ram5", bus.rdata, 32'hDEAD_BEEF);
        bus.addr = 32'h0000_4000;
        #1;
        checkOutput("unmapped", bus.rdata, 32'd0);
        tick();
        bus.re = 1'b0;

        // Output FIFO ordering and handshake
        bus.addr = IO_BASE;
        bus.we   = 1'b1;
        bus.wdata = 32'h41;
        tick();
        bus.wdata = 32'h42;
        tick();
        bus.we = 1'b0;
        #1;
        checkOutput("out_first_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("out_first_data", {24'd0, bus.out_data}, 32'h41);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("out_second_data", {24'd0, bus.out_data}, 32'h42);
        tick();
        checkOutput("out_drained", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Overflow on the ninth push, then clear via STATUS write
        bus.we = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.wdata = 32'(8'h60 + i);
            tick();
        end
        bus.we   = 1'b0;
        bus.re   = 1'b1;
        bus.addr = IO_BASE + 32'd2;
        #1;
        checkOutput("status_ovf", bus.rdata, 32'h0000_0015);
        bus.re = 1'b0;
        bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.re = 1'b1;
        #1;
        checkOutput("status_ovf_clear", bus.rdata, 32'h0000_0005);
        bus.re        = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        bus.out_ready = 1'b0;
        #1;
        checkOutput("out_empty_after_drain", {31'd0, bus.out_valid}, 32'd0);

        // Input FIFO fill, full indication, pop
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'(8'h10 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.addr = IO_BASE + 32'd2;
        bus.re   = 1'b1;
        #1;
        checkOutput("in_full_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("status_in_full", bus.rdata, 32'h0000_080A);
        bus.addr = IO_BASE + 32'd1;
        #1;
        checkOutput("in_head", bus.rdata, 32'h10);
        tick();
        bus.re = 1'b0;
        #1;
        checkOutput("in_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
        bus.re = 1'b1;
        repeat (7) tick();

        // Empty read while a byte arrives
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        #1;
        checkOutput("in_empty_read", bus.rdata, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkOutput("in_late_byte", bus.rdata, 32'h99);
        tick();
        bus.re = 1'b0;

        // Reset in the middle of traffic
        bus.addr     = IO_BASE;
        bus.we       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setIdle();
        bus.addr = IO_BASE + 32'd2;
        bus.re   = 1'b1;
        #1;
        checkOutput("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midreset_status", bus.rdata, 32'h0000_0006);
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus((i / 500) % 2);
            tick();
        end
        reset = 1'b0;
        setIdle();
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
